// File: rtl/decode_issue_ctrl_pkg.sv
// Shared constants and types for the decode-stage issue controller.
// Opcode, immediate-type and FSM encodings used by all decode files.
package decode_issue_ctrl_pkg;

   localparam logic [4:0] OPCODE_LOAD     = 5'b00000;
   localparam logic [4:0] OPCODE_MISC_MEM = 5'b00011;
   localparam logic [4:0] OPCODE_OP_IMM   = 5'b00100;
   localparam logic [4:0] OPCODE_AUIPC    = 5'b00101;
   localparam logic [4:0] OPCODE_STORE    = 5'b01000;
   localparam logic [4:0] OPCODE_OP       = 5'b01100;
   localparam logic [4:0] OPCODE_LUI      = 5'b01101;
   localparam logic [4:0] OPCODE_BRANCH   = 5'b11000;
   localparam logic [4:0] OPCODE_JALR     = 5'b11001;
   localparam logic [4:0] OPCODE_JAL      = 5'b11011;
   localparam logic [4:0] OPCODE_SYSTEM   = 5'b11100;

   localparam logic [2:0] IMM_NONE = 3'b000;
   localparam logic [2:0] IMM_I    = 3'b001;
   localparam logic [2:0] IMM_S    = 3'b010;
   localparam logic [2:0] IMM_B    = 3'b011;
   localparam logic [2:0] IMM_U    = 3'b100;
   localparam logic [2:0] IMM_J    = 3'b101;
   localparam logic [2:0] IMM_CSR  = 3'b110;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [2:0]  imm_type;
   } entry_t;

endpackage

// File: rtl/decode_issue_ctrl_dec.sv
// Fetch-side decode helpers: immediate-type classification and
// immediate extraction for a single RV32I instruction word.
module control_unit
   import decode_issue_ctrl_pkg::*;
(
   input  logic [6:0] OPCODE,
   input  logic [2:0] FUNCT3,
   input  logic       FUNCT7_5,
   output logic [2:0] IMM_TYPE
);

   // Low opcode bits and funct7[5] do not affect the immediate format.
   logic unused_bits;
   assign unused_bits = &{1'b0, OPCODE[1:0], FUNCT7_5};

   always_comb begin
      IMM_TYPE = IMM_NONE;
      unique case (OPCODE[6:2])
         OPCODE_LOAD,
         OPCODE_OP_IMM,
         OPCODE_JALR:   IMM_TYPE = IMM_I;
         OPCODE_STORE:  IMM_TYPE = IMM_S;
         OPCODE_BRANCH: IMM_TYPE = IMM_B;
         OPCODE_LUI,
         OPCODE_AUIPC:  IMM_TYPE = IMM_U;
         OPCODE_JAL:    IMM_TYPE = IMM_J;
         OPCODE_SYSTEM:
            IMM_TYPE = (FUNCT3 != 3'b000) ? IMM_CSR : IMM_NONE;
         default:       IMM_TYPE = IMM_NONE;
      endcase
   end

endmodule

module imm_generator
   import decode_issue_ctrl_pkg::*;
(
   input  logic [31:7] INSTR,
   input  logic [2:0]  IMM_TYPE,
   output logic [31:0] IMM
);

   always_comb begin
      IMM = 32'h0;
      unique case (IMM_TYPE)
         IMM_I:
            IMM = {{20{INSTR[31]}}, INSTR[31:20]};
         IMM_S:
            IMM = {{20{INSTR[31]}}, INSTR[31:25], INSTR[11:7]};
         IMM_B:
            IMM = {{19{INSTR[31]}}, INSTR[31], INSTR[7],
                   INSTR[30:25], INSTR[11:8], 1'b0};
         IMM_U:
            IMM = {INSTR[31:12], 12'h0};
         IMM_J:
            IMM = {{11{INSTR[31]}}, INSTR[31], INSTR[19:12],
                   INSTR[20], INSTR[30:21], 1'b0};
         IMM_CSR:
            IMM = {27'h0, INSTR[19:15]};
         default:
            IMM = 32'h0;
      endcase
   end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode issue controller: two-entry skid buffer between fetch and
// execute, with issue held after a SYSTEM instruction until SYS_DONE.
module decode_issue_ctrl
   import decode_issue_ctrl_pkg::*;
#(
   parameter int HOLD_CNT_W = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  FETCH_VALID,
   output logic                  FETCH_READY,
   input  logic [31:0]           FETCH_INSTR,
   input  logic [31:0]           FETCH_PC,
   output logic                  DEC_VALID,
   input  logic                  DEC_READY,
   output logic [31:0]           DEC_INSTR,
   output logic [31:0]           DEC_PC,
   output logic [31:0]           DEC_IMM,
   output logic [2:0]            DEC_IMM_TYPE,
   input  logic                  FLUSH,
   input  logic                  SYS_DONE,
   output logic [HOLD_CNT_W-1:0] HOLD_CYCLES
);

   entry_t                out_q, out_d;
   entry_t                skid_q, skid_d;
   entry_t                fetch_entry;
   state_t                state_q, state_d;
   logic                  ready_q, ready_d;
   logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [2:0]            fetch_imm_type;
   logic [31:0]           fetch_imm;
   logic                  dec_valid;
   logic                  accept;
   logic                  pop;
   logic                  pop_system;

   control_unit u_control_unit (
      .OPCODE   (FETCH_INSTR[6:0]),
      .FUNCT3   (FETCH_INSTR[14:12]),
      .FUNCT7_5 (FETCH_INSTR[30]),
      .IMM_TYPE (fetch_imm_type)
   );

   imm_generator u_imm_generator (
      .INSTR    (FETCH_INSTR[31:7]),
      .IMM_TYPE (fetch_imm_type),
      .IMM      (fetch_imm)
   );

   always_comb begin
      fetch_entry          = '0;
      fetch_entry.valid    = 1'b1;
      fetch_entry.instr    = FETCH_INSTR;
      fetch_entry.pc       = FETCH_PC;
      fetch_entry.imm      = fetch_imm;
      fetch_entry.imm_type = fetch_imm_type;
   end

   assign accept     = FETCH_VALID && ready_q && !FLUSH;
   assign pop        = dec_valid && DEC_READY && !FLUSH;
   assign pop_system = pop && (out_q.instr[6:2] == OPCODE_SYSTEM);

   // FSM state register
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN:  if (pop_system)         state_d = HOLD;
         HOLD: if (SYS_DONE || FLUSH)  state_d = RUN;
         default:                      state_d = RUN;
      endcase
   end

   // FSM outputs
   always_comb begin
      dec_valid = 1'b0;
      unique case (state_q)
         RUN:     dec_valid = out_q.valid;
         HOLD:    dec_valid = 1'b0;
         default: dec_valid = 1'b0;
      endcase
   end

   // Skid buffer: data fields keep their value when an entry drains so
   // DEC_* do not glitch; only the valid bits carry meaning.
   always_comb begin
      out_d  = out_q;
      skid_d = skid_q;
      if (FLUSH) begin
         out_d.valid  = 1'b0;
         skid_d.valid = 1'b0;
      end else if (pop) begin
         if (skid_q.valid) begin
            out_d = skid_q;
            if (accept) begin
               skid_d = fetch_entry;
            end else begin
               skid_d.valid = 1'b0;
            end
         end else if (accept) begin
            out_d = fetch_entry;
         end else begin
            out_d.valid = 1'b0;
         end
      end else if (accept) begin
         if (!out_q.valid) begin
            out_d = fetch_entry;
         end else begin
            skid_d = fetch_entry;
         end
      end
      ready_d = !skid_d.valid;
   end

   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if ((state_q == HOLD) && out_q.valid && !(&hold_cnt_q)) begin
         hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         out_q      <= '0;
         skid_q     <= '0;
         ready_q    <= 1'b1;
         hold_cnt_q <= '0;
      end else begin
         out_q      <= out_d;
         skid_q     <= skid_d;
         ready_q    <= ready_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign FETCH_READY  = ready_q;
   assign DEC_VALID    = dec_valid;
   assign DEC_INSTR    = out_q.instr;
   assign DEC_PC       = out_q.pc;
   assign DEC_IMM      = out_q.imm;
   assign DEC_IMM_TYPE = out_q.imm_type;
   assign HOLD_CYCLES  = hold_cnt_q;

endmodule
